uart_tx_fifo: RTL
=================

# uart_tx_fifo

Memory-mapped UART transmitter with a small write FIFO. Firmware status and result bytes pass through it on their way to the board UART pin (uo_out[0]), where the integration bench's UART monitor decodes them. It buffers bytes written by the CPU peripheral bus and serialises them as 8N1 frames at a fixed divisor. Default: 115200 baud from the 25 MHz clock.

## Interface
Parameters:
- DIVISOR, 217: clock cycles per UART bit; legal range 16..65535.
- FIFO_DEPTH, 8: entries in the write FIFO; must be a power of two, 2..16.

Ports:
- clk  input  1  system clock (25 MHz nominal); single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe from the peripheral bus.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO not full; a write is accepted only when wr_en && wr_ready.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.
- txd  output  1  serial line, idle high.
- irq  output  1  TX-empty interrupt (see Configuration).

## Operation
- FIFO: circular buffer with read/write pointers one bit wider than the index; full = MSBs differ and index bits equal.
- FIFO write when wr_en && wr_ready. Writes with wr_ready=0 are dropped silently.
- Full FIFO plus a same-cycle pop: wr_ready still reads 0 that cycle. There is no pass-through.
- FSM states:
  - IDLE: txd=1. When the FIFO is non-empty, pop into shift register, go to START.
  - START: txd=0 for DIVISOR cycles, then DATA.
  - DATA: txd=shift[0], LSB first. Shift right each bit period. After bit 7, go to STOP.
  - STOP: txd=1 for DIVISOR cycles. At the end of the period, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter: counts DIVISOR-1 down to 0, reloaded on every bit boundary. Bit counter is 3 bits.
- busy = (state != IDLE) || !empty.
- Outputs after reset (asynchronous):
  - txd=1, wr_ready=1, busy=0, fifo_count=0, irq=0.
  - FSM in IDLE, pointers cleared.
- Reset mid-frame aborts the frame. txd returns to 1 immediately, and queued data is discarded.

## Timing
- Write accepted at edge N into an empty FIFO with the FSM in IDLE: the pop and START entry happen at edge N+1, and txd goes low after edge N+1.
- fifo_count reads 1 after edge N and 0 after edge N+1.
- Frame length: exactly 10×DIVISOR cycles (2170 at default).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last STOP cycle, with zero idle cycles between frames.
- txd is driven from a flop, so it is glitch-free.
- wr_ready updates one cycle after the write or pop that changes the full status.

## Configuration
- UART_TX_IRQ_EN defined:
  - irq is a registered level, set when the FIFO count drops to 0 as a result of a pop.
  - irq is cleared by the next accepted write or by reset.
- UART_TX_IRQ_EN undefined:
  - irq is tied to 0 and the irq flop is not synthesised.
  - All other behaviour is identical.

## Structure
- Shared package uart_pkg holds:
  - the state enum tx_state_t with values IDLE, START, DATA, STOP;
  - localparam UART_DIV_115200_25M = 217.
- One sub-module, uart_tx_sfifo: a parameterised synchronous FIFO with push, pop, full, empty and count. The top level holds the FSM, baud counter and shift register.
- Target size is about 200 RTL lines in total.

## Test plan
- Single byte:
  - Stimulus: reset, then write 0x4F.
  - Response: txd low after the next edge. Bit sequence 0,1,1,1,1,0,0,1,0,1, each held 217 cycles. The monitor decodes 'O'. busy falls after cycle 2170 of the frame.
- Burst:
  - Stimulus: write 0x30..0x38 on 9 consecutive cycles.
  - Response: the 1st byte is popped immediately. The next 8 bytes fill the FIFO (fifo_count=8) and wr_ready falls.
- Full FIFO:
  - Stimulus: hold a write of 0xAA while the FIFO is full.
  - Response: 0xAA is never transmitted. Output is 0x30..0x38 in order, spaced exactly 2170 cycles start-to-start.
- String:
  - Stimulus: write "OK\n" (0x4F 0x4B 0x0A).
  - Response: the monitor sees 3 bytes, with no idle gap between the stop bit of one frame and the start bit of the next.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during DATA bit 3 of 0x55, with 2 bytes queued.
  - Response: txd=1 and fifo_count=0 immediately. No further frames follow after release.
- IRQ, with UART_TX_IRQ_EN defined:
  - Stimulus: write 2 bytes.
  - Response: irq rises on the pop of the 2nd byte. A subsequent write clears irq one cycle later.
  - Built without the macro, irq stays 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice: transmitter state
// encoding, the default baud divisor for 115200 baud from a 25 MHz clock, and
// a helper that turns a divisor into the baud counter reload value.
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DIV_115200_25M = 217;

  localparam logic [2:0] LAST_DATA_BIT = 3'd7;

  // The baud counter runs DIVISOR-1 down to 0, so each bit lasts DIVISOR cycles.
  function automatic logic [15:0] baud_reload(input int div);
    return 16'(div - 1);
  endfunction

endpackage

// File: rtl/uart_tx_sfifo.sv
// -----------------------------------------------------------------------------
// uart_tx_sfifo
// Parameterised synchronous FIFO (circular buffer). Pointers are one bit wider
// than the index so full and empty are distinguishable without a counter.
// Reads are combinational from the head entry (show-ahead).
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (pointers only)
//   push       in   write request, ignored when full
//   push_data  in   WIDTH-bit data to write
//   pop        in   read request, ignored when empty
//   pop_data   out  head entry
//   full       out  no free entries
//   empty      out  no valid entries
//   count      out  number of valid entries
// -----------------------------------------------------------------------------
module uart_tx_sfifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  // Wrap bits differ with equal index bits: the writer has lapped the reader.
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign count    = r_wr_ptr - r_rd_ptr;
  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage array; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Memory-mapped UART transmitter: bytes written from the peripheral bus are
// queued in a small FIFO and serialised as 8N1 frames, DIVISOR clocks per bit.
// Optional feature macro: UART_TX_IRQ_EN -- when defined, irq is a registered
// TX-empty level (set when a pop empties the FIFO, cleared by the next accepted
// write); when undefined, irq is tied low.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   wr_en       in   write strobe
//   wr_data     in   byte to transmit
//   wr_ready    out  FIFO not full
//   busy        out  FIFO non-empty or frame in progress
//   fifo_count  out  bytes queued, excluding the byte being shifted
//   txd         out  serial line, idle high, driven from a flop
//   irq         out  TX-empty interrupt
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIVISOR    = UART_DIV_115200_25M,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          txd,
  output logic                          irq
);

  localparam logic [15:0] BAUD_RELOAD = baud_reload(DIVISOR);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [15:0] r_baud;
  logic [15:0] w_baud_nxt;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_txd;
  logic        w_txd_nxt;

  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_rd_data;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  uart_tx_sfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (w_pop),
    .pop_data  (w_rd_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign wr_ready   = !w_full;
  assign fifo_count = w_count;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign txd        = r_txd;

  // State, baud counter, bit counter, shift register and line flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // Next-state logic; txd is computed for the state being entered so the
  // line flop changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = START;
          w_txd_nxt   = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_baud == 16'd0) begin
          w_baud_nxt  = BAUD_RELOAD;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      DATA: begin
        if (r_baud == 16'd0) begin
          w_baud_nxt = BAUD_RELOAD;
          if (r_bit == LAST_DATA_BIT) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      STOP: begin
        if (r_baud == 16'd0) begin
          // Chain straight into the next frame when data is waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_rd_data;
            w_baud_nxt  = BAUD_RELOAD;
            w_txd_nxt   = 1'b0;
            w_state_nxt = START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      default: begin
        w_txd_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq;
  logic w_accept;

  assign w_accept = wr_en && !w_full;
  assign irq      = r_irq;

  // TX-empty level: an accepted write clears it, a pop of the last entry sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else if (w_accept) begin
      r_irq <= 1'b0;
    end else if (w_pop && (w_count == ($clog2(FIFO_DEPTH)+1)'(1))) begin
      r_irq <= 1'b1;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
